// File: rtl/cve2_obi_mem_responder.sv
// OBI-style memory responder with configurable response latency and
// outstanding-request limit. It backs a word-addressed RAM with byte-lane writes.
module cve2_obi_mem_responder #(
  parameter int unsigned DEPTH           = 256,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_i
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  if ((DEPTH < 4) || (DEPTH > 4096) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two in 4..4096");
  end
  if ((LATENCY < 1) || (LATENCY > 4)) begin : g_bad_latency
    $error("LATENCY must be in 1..4");
  end
  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 4)) begin : g_bad_outstanding
    $error("MAX_OUTSTANDING must be in 1..4");
  end

  logic [31:0]      mem [DEPTH];
  logic [31:0]      addr_off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             txn;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [OUT_W-1:0] outstanding_q;

  logic             pipe_valid_q [LATENCY];
  logic             pipe_err_q   [LATENCY];
  logic [31:0]      pipe_rdata_q [LATENCY];

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign addr_off = addr_i - BASE_ADDR;
  assign in_range = addr_off < MEM_BYTES;
  assign idx      = addr_off[IDX_W+1:2];

  // A response leaving this cycle frees a slot, so a full counter can still grant.
  assign gnt_o = req_i & ~stall_i & ~rst_i & ((outstanding_q < OUT_MAX) | rvalid_o);
  assign txn   = gnt_o;

  always_ff @(posedge clk_i) begin
    if (txn && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (!in_range) begin
      rsp_err = 1'b1;
    end else if (!we_i) begin
      rsp_rdata = mem[idx];
    end
  end

  // Stage 0 is loaded at the grant edge; payload is zeroed for empty slots.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_err_q[i]   <= 1'b0;
        pipe_rdata_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= txn;
      pipe_err_q[0]   <= txn & rsp_err;
      pipe_rdata_q[0] <= txn ? rsp_rdata : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
        pipe_rdata_q[i] <= pipe_rdata_q[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid_q[LATENCY-1];
  assign rdata_o  = pipe_rdata_q[LATENCY-1];
  assign err_o    = pipe_err_q[LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      case ({txn, rvalid_o})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Directed bench for cve2_obi_mem_responder: three instances cover the default,
// offset-base/deep-latency and latency-2 configurations.
module tb_cve2_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [31:0] rdata  [3];
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        stall;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cve2_obi_mem_responder u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]), .stall_i(stall)
  );

  cve2_obi_mem_responder #(
    .BASE_ADDR(32'h0000_1000), .LATENCY(3), .MAX_OUTSTANDING(2)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]), .stall_i(stall)
  );

  cve2_obi_mem_responder #(
    .LATENCY(2)
  ) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]), .stall_i(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic drive(input int i, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    req[2] = 1'b0;
    req[i] = r;
    we     = w;
    addr   = a;
    be     = b;
    wdata  = d;
  endtask

  task automatic single(input int i, input int lat, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    drive(i, 1'b1, w, a, b, d);
    @(negedge clk);
    chk({tag, " gnt"}, 32'(gnt[i]), 32'd1);
    drive(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        chk({tag, " early rvalid"}, 32'(rvalid[i]), 32'd0);
      end else begin
        chk({tag, " rvalid"}, 32'(rvalid[i]), 32'd1);
        chk({tag, " rdata"}, rdata[i], exp_rd);
        chk({tag, " err"}, 32'(err[i]), 32'(exp_err));
      end
    end
  endtask

  logic [8:0] exp_g;
  logic [8:0] exp_rv;
  int         nk;
  int         nrv;
  int         nseen;

  initial begin
    rst    = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    req[2] = 1'b0;
    we     = 1'b0;
    addr   = 32'h0;
    be     = 4'h0;
    wdata  = 32'h0;
    stall  = 1'b0;

    // Reset: outputs quiet and no grant even with a request pending.
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b1;
    @(negedge clk);
    chk("reset gnt", 32'(gnt[0]), 32'd0);
    chk("reset rvalid", 32'(rvalid[0]), 32'd0);
    chk("reset rdata", rdata[0], 32'h0);
    chk("reset err", 32'(err[0]), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    chk("idle rvalid", 32'(rvalid[0]), 32'd0);

    // Back-to-back write then read on the default instance.
    drive(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("b2b wr gnt", 32'(gnt[0]), 32'd1);
    drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b rd gnt", 32'(gnt[0]), 32'd1);
    chk("b2b wr rvalid", 32'(rvalid[0]), 32'd1);
    chk("b2b wr rdata", rdata[0], 32'h0);
    chk("b2b wr err", 32'(err[0]), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b rd rvalid", 32'(rvalid[0]), 32'd1);
    chk("b2b rd rdata", rdata[0], 32'hDEAD_BEEF);
    chk("b2b rd err", 32'(err[0]), 32'd0);
    @(negedge clk);
    chk("b2b after rvalid", 32'(rvalid[0]), 32'd0);

    // Partial byte-lane write, zero-enable write, last word, out-of-range accesses.
    single(0, 1, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, 32'h0, 1'b0, "wr_partial");
    single(0, 1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDE22_BE44, 1'b0, "rd_partial");
    single(0, 1, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr_be0");
    single(0, 1, 1'b0, 32'h13, 4'h0, 32'h0, 32'hDE22_BE44, 1'b0, "rd_be0");
    single(0, 1, 1'b1, 32'h3FC, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, "wr_last");
    single(0, 1, 1'b0, 32'h3FC, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, "rd_last");
    single(0, 1, 1'b0, 32'h400, 4'h0, 32'h0, 32'h0, 1'b1, "rd_oor");
    single(0, 1, 1'b1, 32'h410, 4'hF, 32'h0, 32'h0, 1'b1, "wr_oor");
    single(0, 1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDE22_BE44, 1'b0, "rd_after_oor");

    // Offset base, latency 3.
    single(1, 3, 1'b1, 32'h1000, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, "b_wr");
    single(1, 3, 1'b0, 32'h0FFC, 4'h0, 32'h0, 32'h0, 1'b1, "b_rd_below_base");
    single(1, 3, 1'b0, 32'h1400, 4'h0, 32'h0, 32'h0, 1'b1, "b_rd_above");
    single(1, 3, 1'b0, 32'h1000, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, "b_rd_base");
    for (int k = 0; k < 4; k++) begin
      single(1, 3, 1'b1, 32'h1000 + 32'(k * 4), 4'hF, 32'hB000_0000 + 32'(k),
             32'h0, 1'b0, "b_preload");
    end

    // Held request against MAX_OUTSTANDING=2 with LATENCY=3.
    exp_g  = 9'b0_0001_1011;
    exp_rv = 9'b0_1101_1000;
    nk     = 0;
    nrv    = 0;
    nseen  = 0;
    for (int c = 0; c < 9; c++) begin
      if (c < 6) drive(1, 1'b1, 1'b0, 32'h1000 + 32'(nk * 4), 4'h0, 32'h0);
      else       drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("burst gnt", 32'(gnt[1]), 32'(exp_g[c]));
      chk("burst rvalid", 32'(rvalid[1]), 32'(exp_rv[c]));
      if (exp_rv[c]) begin
        chk("burst rdata", rdata[1], 32'hB000_0000 + 32'(nrv));
        nrv++;
      end
      if (rvalid[1]) nseen++;
      if (gnt[1]) nk++;
    end
    chk("burst rvalid count", 32'(nseen), 32'd4);

    // Stall while a latency-2 read is in flight.
    single(2, 2, 1'b1, 32'h20, 4'hF, 32'h5A5A_A5A5, 32'h0, 1'b0, "c_wr");
    drive(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    chk("stall pre gnt", 32'(gnt[2]), 32'd1);
    for (int s = 1; s <= 5; s++) begin
      drive(2, 1'b1, 1'b0, 32'h24, 4'h0, 32'h0);
      stall = 1'b1;
      @(negedge clk);
      chk("stall gnt", 32'(gnt[2]), 32'd0);
      chk("stall rvalid", 32'(rvalid[2]), 32'(s == 2));
      if (s == 2) chk("stall rdata", rdata[2], 32'h5A5A_A5A5);
    end
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stall = 1'b0;
    @(negedge clk);
    chk("stall end rvalid", 32'(rvalid[2]), 32'd0);

    // Reset one cycle after a latency-2 grant drops its response.
    drive(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst pre gnt", 32'(gnt[2]), 32'd1);
    drive(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst gnt", 32'(gnt[2]), 32'd0);
    chk("rst rvalid", 32'(rvalid[2]), 32'd0);
    drive(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst gnt", 32'(gnt[2]), 32'd1);
    chk("dropped rvalid", 32'(rvalid[2]), 32'd0);
    chk("dropped rdata", rdata[2], 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("post rst early rvalid", 32'(rvalid[2]), 32'd0);
    @(negedge clk);
    chk("post rst rvalid", 32'(rvalid[2]), 32'd1);
    chk("post rst rdata", rdata[2], 32'h5A5A_A5A5);
    chk("post rst err", 32'(err[2]), 32'd0);
    @(negedge clk);
    chk("post rst single pulse", 32'(rvalid[2]), 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cve2_obi_mem_responder.md
CVE2_OBI_MEM_RESPONDER -- requirements
Module: cve2_obi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning memory size in 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0 (DEPTH*4-aligned).
REQ-003 SHALL have parameter LATENCY, default 1, meaning cycles from grant to rvalid (legal 1..4).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, meaning granted-but-unanswered request limit (legal 1..4).
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port req_i, input, 1, request valid from initiator.
REQ-008 SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-009 SHALL have port addr_i, input, 32, byte address; bits [1:0] ignored.
REQ-010 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port be_i, input, 4, byte enables for writes.
REQ-012 SHALL have port wdata_i, input, 32, write data.
REQ-013 SHALL have port rvalid_o, output, 1, response valid (no backpressure).
REQ-014 SHALL have port rdata_o, output, 32, read data, valid with rvalid_o.
REQ-015 SHALL have port err_o, output, 1, error response, valid with rvalid_o.
REQ-016 SHALL have port stall_i, input, 1, forces gnt_o=0 while high (test/back-pressure hook).

Function
REQ-017 gnt_o SHALL be combinational: req_i & !stall_i & (outstanding < MAX_OUTSTANDING | rvalid_o).
REQ-018 Transaction SHALL occur only on req_i & gnt_o; addr/we/be/wdata sampled that cycle only.
REQ-019 In-range = (addr_i - BASE_ADDR) < DEPTH*4, unsigned 32-bit subtraction (wrap-around below BASE_ADDR => out of range).
REQ-020 Granted in-range write SHALL update each byte lane with be_i[n]=1 at that clock edge; lanes with be_i[n]=0 unchanged; be_i=0 legal, no update, err=0.
REQ-021 Granted in-range read SHALL capture the memory word at the grant edge (reflects all previously granted writes).
REQ-022 Granted out-of-range access SHALL not modify memory and SHALL respond err_o=1, rdata_o=0.
REQ-023 Write responses SHALL have rdata_o=0, err_o=0 (in range).
REQ-024 Each grant SHALL produce exactly one rvalid_o pulse exactly LATENCY cycles later (grant at edge N => rvalid_o high in cycle N+LATENCY); responses in grant order.
REQ-025 Response path SHALL be a LATENCY-stage shift pipeline of {valid, rdata, err}; rdata_o/err_o SHALL be 0 when rvalid_o=0.
REQ-026 outstanding counter (0..MAX_OUTSTANDING) SHALL increment on grant, decrement on rvalid_o, unchanged when both occur.
REQ-027 Counter SHALL never exceed MAX_OUTSTANDING nor underflow; simultaneous grant + rvalid at MAX SHALL be accepted.
REQ-028 With MAX_OUTSTANDING >= LATENCY and stall_i=0, back-to-back req_i SHALL be granted every cycle.
REQ-029 stall_i SHALL not affect in-flight responses.

Reset
REQ-030 While rst_i=1 at a clock edge: pipeline valids and outstanding SHALL clear to 0; rvalid_o=0, rdata_o=0, err_o=0 from the next cycle.
REQ-031 gnt_o SHALL be 0 during any cycle with rst_i=1.
REQ-032 Responses in flight at reset SHALL be dropped (never issued); memory contents SHALL not be cleared.

Verification
REQ-033 Defaults; write addr 0x10, be=4'hF, wdata=0xDEADBEEF, then read 0x10 -> gnt_o=1 both; read rvalid_o one cycle after its grant, rdata_o=0xDEADBEEF, err_o=0.
REQ-034 Write 0x10 be=4'b0101 wdata=0x11223344 over 0xDEADBEEF, read back -> rdata_o=0xDE22BE44.
REQ-035 Read addr 0x400 (DEPTH=256) and BASE_ADDR=0x1000 read of 0x0FFC -> err_o=1, rdata_o=0, memory unchanged.
REQ-036 LATENCY=3, MAX_OUTSTANDING=2, req_i held 6 cycles -> grants pattern 1,1,0,1,1,0; outstanding never >2; 4 rvalids, in order, each 3 cycles after grant.
REQ-037 stall_i=1 with req_i=1 for 5 cycles -> gnt_o=0 throughout; earlier in-flight read still returns on schedule.
REQ-038 LATENCY=2, grant read, assert rst_i one cycle later -> no rvalid_o ever for that read; outstanding=0; next request granted immediately after reset deasserts.
